// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search controller and its memory arbiter.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_WAIT,
    ST_KSA_GO,
    ST_KSA_WAIT,
    ST_DEC_GO,
    ST_DEC_WAIT,
    ST_CHK_SETUP,
    ST_CHK_READ,
    ST_CHK_SAMPLE,
    ST_CHK_TEST,
    ST_NEXT_KEY,
    ST_FOUND,
    ST_FAIL
  } state_e;

  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_INIT,
    GNT_KSA,
    GNT_DEC,
    GNT_CHK
  } grant_e;

  localparam logic [1:0] MEM_SEL_NONE = 2'd0;
  localparam logic [1:0] MEM_SEL_S    = 2'd1;
  localparam logic [1:0] MEM_SEL_ENC  = 2'd2;
  localparam logic [1:0] MEM_SEL_DEC  = 2'd3;

  localparam logic [7:0] ASCII_LO = 8'h61;
  localparam logic [7:0] ASCII_HI = 8'h7A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  // A plaintext byte is acceptable if it is lowercase ASCII or a space.
  function automatic logic is_msg_char(input logic [7:0] b);
    return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SP);
  endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_if.sv
// Memory-side bundle: S-RAM, encrypted ROM and decrypted RAM ports.
interface rc4_key_search_ctrl_if;
  logic [7:0] s_addr;
  logic [7:0] s_data;
  logic       s_wen;
  logic [7:0] s_q;
  logic [7:0] e_addr;
  logic [7:0] e_q;
  logic [7:0] d_addr;
  logic [7:0] d_data;
  logic       d_wen;
  logic [7:0] d_q;

  modport master (
    output s_addr, s_data, s_wen, e_addr, d_addr, d_data, d_wen,
    input  s_q, e_q, d_q
  );

  modport slave (
    input  s_addr, s_data, s_wen, e_addr, d_addr, d_data, d_wen,
    output s_q, e_q, d_q
  );
endinterface

// File: rtl/rc4_mem_arbiter.sv
// Combinational grant-indexed mux: only the granted requester reaches the memories.
module rc4_mem_arbiter
  import rc4_pkg::*;
(
  input  grant_e     grant,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_data,
  input  logic       init_wen,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] ksa_data,
  input  logic       ksa_wen,
  input  logic [7:0] dec_addr,
  input  logic [7:0] dec_data,
  input  logic       dec_wen,
  input  logic [1:0] dec_sel,
  input  logic [7:0] chk_addr,
  input  logic [7:0] s_q,
  input  logic [7:0] e_q,
  output logic [7:0] s_addr,
  output logic [7:0] s_data,
  output logic       s_wen,
  output logic [7:0] e_addr,
  output logic [7:0] d_addr,
  output logic [7:0] d_data,
  output logic       d_wen,
  output logic [7:0] dec_q
);

  always_comb begin
    s_addr = '0;
    s_data = '0;
    s_wen  = 1'b0;
    e_addr = '0;
    d_addr = '0;
    d_data = '0;
    d_wen  = 1'b0;
    dec_q  = '0;
    case (grant)
      GNT_INIT: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wen  = init_wen;
      end
      GNT_KSA: begin
        s_addr = ksa_addr;
        s_data = ksa_data;
        s_wen  = ksa_wen;
      end
      GNT_DEC: begin
        case (dec_sel)
          MEM_SEL_S: begin
            s_addr = dec_addr;
            s_data = dec_data;
            s_wen  = dec_wen;
            dec_q  = s_q;
          end
          MEM_SEL_ENC: begin
            e_addr = dec_addr;
            dec_q  = e_q;
          end
          MEM_SEL_DEC: begin
            d_addr = dec_addr;
            d_data = dec_data;
            d_wen  = dec_wen;
          end
          default: ;
        endcase
      end
      // The checker only ever reads the decrypted RAM.
      GNT_CHK: d_addr = chk_addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// RC4 key-search scheduler: sequences S-init, KSA and decrypt per candidate key,
// then scans the decrypted message for printable lowercase/space bytes.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int              KEY_W     = 24,
  parameter int              MSG_LEN   = 32,
  parameter logic [KEY_W-1:0] KEY_START = 24'h0,
  parameter logic [KEY_W-1:0] KEY_END   = 24'h3FFFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             init_start,
  input  logic             init_done,
  output logic             ksa_start,
  input  logic             ksa_done,
  output logic             dec_start,
  input  logic             dec_done,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       init_data,
  input  logic             init_wen,
  input  logic [7:0]       ksa_addr,
  input  logic [7:0]       ksa_data,
  input  logic             ksa_wen,
  input  logic [7:0]       dec_addr,
  input  logic [7:0]       dec_data,
  input  logic             dec_wen,
  input  logic [1:0]       dec_sel,
  rc4_key_search_ctrl_if.master mem,
  output logic [7:0]       dec_q,
  output logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             found,
  output logic             fail
);

  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  state_e           state_q, state_d;
  grant_e           grant_q, grant_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             busy_q, busy_d;
  logic             found_q, found_d;
  logic             fail_q, fail_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_NONE;
      key_q   <= KEY_START;
      idx_q   <= '0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
      found_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      found_q <= found_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    key_d   = key_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    busy_d  = busy_q;
    found_d = found_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          found_d = 1'b0;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          key_d   = KEY_START;
          idx_d   = '0;
          state_d = ST_INIT_GO;
        end
      end
      ST_INIT_GO: begin
        grant_d = GNT_INIT;
        state_d = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: if (init_done) state_d = ST_KSA_GO;
      ST_KSA_GO: begin
        grant_d = GNT_KSA;
        state_d = ST_KSA_WAIT;
      end
      ST_KSA_WAIT: if (ksa_done) state_d = ST_DEC_GO;
      ST_DEC_GO: begin
        grant_d = GNT_DEC;
        state_d = ST_DEC_WAIT;
      end
      ST_DEC_WAIT: begin
        if (dec_done) begin
          grant_d = GNT_CHK;
          state_d = ST_CHK_SETUP;
        end
      end
      // d_addr holds idx through SETUP/READ so the 2-cycle RAM output lands in SAMPLE.
      ST_CHK_SETUP: state_d = ST_CHK_READ;
      ST_CHK_READ:  state_d = ST_CHK_SAMPLE;
      ST_CHK_SAMPLE: begin
        byte_d  = mem.d_q;
        state_d = ST_CHK_TEST;
      end
      ST_CHK_TEST: begin
        if (!is_msg_char(byte_q)) begin
          state_d = ST_NEXT_KEY;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_FOUND;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_CHK_SETUP;
        end
      end
      ST_NEXT_KEY: begin
        grant_d = GNT_NONE;
        if (key_q == KEY_END) begin
          state_d = ST_FAIL;
        end else begin
          key_d   = key_q + KEY_W'(1);
          idx_d   = '0;
          state_d = ST_INIT_GO;
        end
      end
      ST_FOUND: begin
        grant_d = GNT_NONE;
        busy_d  = 1'b0;
        found_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        grant_d = GNT_NONE;
        busy_d  = 1'b0;
        fail_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = GNT_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign init_start = (state_q == ST_INIT_GO);
  assign ksa_start  = (state_q == ST_KSA_GO);
  assign dec_start  = (state_q == ST_DEC_GO);
  assign key        = key_q;
  assign busy       = busy_q;
  assign found      = found_q;
  assign fail       = fail_q;

  rc4_mem_arbiter u_arb (
    .grant     (grant_q),
    .init_addr (init_addr),
    .init_data (init_data),
    .init_wen  (init_wen),
    .ksa_addr  (ksa_addr),
    .ksa_data  (ksa_data),
    .ksa_wen   (ksa_wen),
    .dec_addr  (dec_addr),
    .dec_data  (dec_data),
    .dec_wen   (dec_wen),
    .dec_sel   (dec_sel),
    .chk_addr  (8'(idx_q)),
    .s_q       (mem.s_q),
    .e_q       (mem.e_q),
    .s_addr    (mem.s_addr),
    .s_data    (mem.s_data),
    .s_wen     (mem.s_wen),
    .e_addr    (mem.e_addr),
    .d_addr    (mem.d_addr),
    .d_data    (mem.d_data),
    .d_wen     (mem.d_wen),
    .dec_q     (dec_q)
  );

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: stub phase FSMs, a key-dependent 2-cycle decrypted RAM,
// and a key-space search model that predicts result, retries and checker read order.
module tb_rc4_key_search_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_r [2];
  logic        init_start_w [2], ksa_start_w [2], dec_start_w [2];
  logic        init_done_w [2], ksa_done_w [2], dec_done_w [2];
  logic [2:0]  ad [2];
  logic        force_init = 1'b0, force_ksa = 1'b0, force_dec = 1'b0;
  logic [7:0]  init_addr = '0, init_data = '0, ksa_addr = '0, ksa_data = '0;
  logic [7:0]  dec_addr = '0, dec_data = '0, s_q_r = '0, e_q_r = '0;
  logic        init_wen = 1'b0, ksa_wen = 1'b0, dec_wen = 1'b0;
  logic [1:0]  dec_sel = 2'd0;
  logic [7:0]  dec_q_w [2];
  logic [23:0] key_w [2];
  logic        busy_w [2], found_w [2], fail_w [2];
  logic [7:0]  d_addr_w [2], pipe1 [2], dq [2];
  int          lat_init = 3, lat_ksa = 3, lat_dec = 3;
  int          stub_cnt [2], stub_ph [2];
  int          init_cnt [2], ksa_cnt [2], dec_cnt [2];
  int          rd_q [$];
  int          exp_rd [$];
  bit          chk_on = 1'b0, rd_first = 1'b0;
  logic [7:0]  rd_last = '0;
  int          cyc = 0, last_rd_cyc = 0;
  int          bad_idx [16];
  logic [7:0]  bad_chr [16];
  logic [7:0]  msg_txt [32];
  int          base_init, base_ksa, base_dec, base_rd;
  int          vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  rc4_key_search_ctrl_if mem0 ();
  rc4_key_search_ctrl_if mem1 ();

  assign mem0.s_q = s_q_r;
  assign mem0.e_q = e_q_r;
  assign mem0.d_q = dq[0];
  assign mem1.s_q = s_q_r;
  assign mem1.e_q = e_q_r;
  assign mem1.d_q = dq[1];
  assign d_addr_w[0] = mem0.d_addr;
  assign d_addr_w[1] = mem1.d_addr;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      init_done_w[i] = ad[i][0] | force_init;
      ksa_done_w[i]  = ad[i][1] | force_ksa;
      dec_done_w[i]  = ad[i][2] | force_dec;
    end
  end

  rc4_key_search_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start_r[0]),
    .init_start(init_start_w[0]), .init_done(init_done_w[0]),
    .ksa_start(ksa_start_w[0]), .ksa_done(ksa_done_w[0]),
    .dec_start(dec_start_w[0]), .dec_done(dec_done_w[0]),
    .init_addr(init_addr), .init_data(init_data), .init_wen(init_wen),
    .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wen(ksa_wen),
    .dec_addr(dec_addr), .dec_data(dec_data), .dec_wen(dec_wen), .dec_sel(dec_sel),
    .mem(mem0.master), .dec_q(dec_q_w[0]), .key(key_w[0]),
    .busy(busy_w[0]), .found(found_w[0]), .fail(fail_w[0])
  );

  rc4_key_search_ctrl #(.KEY_START(24'd5), .KEY_END(24'd5)) dut_f (
    .clk(clk), .reset_n(reset_n), .start(start_r[1]),
    .init_start(init_start_w[1]), .init_done(init_done_w[1]),
    .ksa_start(ksa_start_w[1]), .ksa_done(ksa_done_w[1]),
    .dec_start(dec_start_w[1]), .dec_done(dec_done_w[1]),
    .init_addr(init_addr), .init_data(init_data), .init_wen(init_wen),
    .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wen(ksa_wen),
    .dec_addr(dec_addr), .dec_data(dec_data), .dec_wen(dec_wen), .dec_sel(dec_sel),
    .mem(mem1.master), .dec_q(dec_q_w[1]), .key(key_w[1]),
    .busy(busy_w[1]), .found(found_w[1]), .fail(fail_w[1])
  );

  // Decrypted text as a function of the candidate key: one bad byte for listed keys.
  function automatic logic [7:0] msg_byte(input logic [23:0] k, input logic [7:0] a);
    if (k < 24'd16 && bad_idx[k[3:0]] == int'(a)) return bad_chr[k[3:0]];
    return msg_txt[a[4:0]];
  endfunction

  function automatic bit printable(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
  endfunction

  // Phase stubs answer each start with a done pulse a few cycles later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        stub_cnt[i] <= 0;
        stub_ph[i]  <= 0;
        ad[i]       <= 3'b000;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        ad[i] <= 3'b000;
        if (init_start_w[i]) begin
          stub_cnt[i] <= lat_init; stub_ph[i] <= 0;
        end else if (ksa_start_w[i]) begin
          stub_cnt[i] <= lat_ksa; stub_ph[i] <= 1;
        end else if (dec_start_w[i]) begin
          stub_cnt[i] <= lat_dec; stub_ph[i] <= 2;
        end else if (stub_cnt[i] > 0) begin
          stub_cnt[i] <= stub_cnt[i] - 1;
          if (stub_cnt[i] == 1) ad[i][stub_ph[i]] <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pipe1[i] <= msg_byte(key_w[i], d_addr_w[i]);
      dq[i]    <= pipe1[i];
    end
  end

  // Count phase starts and log the checker's address sequence on the main instance.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (init_start_w[i]) init_cnt[i] <= init_cnt[i] + 1;
      if (ksa_start_w[i])  ksa_cnt[i]  <= ksa_cnt[i] + 1;
      if (dec_start_w[i])  dec_cnt[i]  <= dec_cnt[i] + 1;
    end
    if (init_start_w[0] || !busy_w[0]) begin
      chk_on <= 1'b0;
    end else if (chk_on && (rd_first || d_addr_w[0] != rd_last)) begin
      rd_q.push_back(int'(d_addr_w[0]));
      rd_last     <= d_addr_w[0];
      rd_first    <= 1'b0;
      last_rd_cyc <= cyc;
    end
    if (dec_done_w[0] && busy_w[0]) begin
      chk_on   <= 1'b1;
      rd_first <= 1'b1;
    end
    cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_bad();
    for (int i = 0; i < 16; i++) begin
      bad_idx[i] = -1;
      bad_chr[i] = 8'h41;
    end
  endtask

  task automatic start_search(input int lane);
    base_init = init_cnt[lane];
    base_ksa  = ksa_cnt[lane];
    base_dec  = dec_cnt[lane];
    base_rd   = rd_q.size();
    start_r[lane] = 1'b1;
    @(negedge clk);
    start_r[lane] = 1'b0;
    check_val("start_to_init_start", 32'(init_start_w[lane]), 32'd1);
    check_val("busy_after_start", 32'(busy_w[lane]), 32'd1);
  endtask

  task automatic wait_and_check(input int lane, input int ks, input int ke);
    bit ef = 1'b0;
    int ek = ke;
    int tries = 0;
    int n;
    int found_cyc;
    logic [7:0] b;
    exp_rd.delete();
    for (int k = ks; k <= ke && !ef; k++) begin
      bit ok = 1'b1;
      tries++;
      for (int a = 0; a < 32; a++) begin
        exp_rd.push_back(a);
        b = msg_byte(24'(k), 8'(a));
        if (!printable(b)) begin
          ok = 1'b0;
          break;
        end
      end
      if (ok) begin
        ef = 1'b1;
        ek = k;
      end
    end
    for (n = 0; n < 20000 && busy_w[lane]; n++) @(negedge clk);
    found_cyc = cyc;
    check_val("search_timeout", 32'(busy_w[lane]), 32'd0);
    $display("lane %0d search keys %0d..%0d: found=%0d fail=%0d key=%0d (model found=%0d key=%0d tries=%0d)",
             lane, ks, ke, found_w[lane], fail_w[lane], key_w[lane], ef, ek, tries);
    check_val("found", 32'(found_w[lane]), 32'(ef));
    check_val("fail", 32'(fail_w[lane]), 32'(!ef));
    check_val("final_key", 32'(key_w[lane]), 32'(ek));
    check_val("init_starts", 32'(init_cnt[lane] - base_init), 32'(tries));
    check_val("ksa_starts", 32'(ksa_cnt[lane] - base_ksa), 32'(tries));
    check_val("dec_starts", 32'(dec_cnt[lane] - base_dec), 32'(tries));
    if (lane == 0) begin
      check_val("read_count", 32'(rd_q.size() - base_rd), 32'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size() && base_rd + i < rd_q.size(); i++)
        check_val("read_addr", 32'(rd_q[base_rd + i]), 32'(exp_rd[i]));
      if (ef) check_val("found_latency", 32'(found_cyc - last_rd_cyc), 32'd5);
    end
  endtask

  initial begin
    string hs;
    int n;
    logic [7:0] r1, r2, r3;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    hs = "hello world from the key cracker";
    for (int i = 0; i < 32; i++) msg_txt[i] = hs[i];
    clear_bad();

    // Reset state, with a request pending that must not reach the S-RAM.
    init_wen = 1'b1; init_addr = 8'h77;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy_w[0]), 32'd0);
    check_val("rst_found", 32'(found_w[0]), 32'd0);
    check_val("rst_fail", 32'(fail_w[0]), 32'd0);
    check_val("rst_key", 32'(key_w[0]), 32'd0);
    check_val("rst_key_f", 32'(key_w[1]), 32'd5);
    check_val("rst_init_start", 32'(init_start_w[0]), 32'd0);
    check_val("rst_s_wen", 32'(mem0.s_wen), 32'd0);
    check_val("rst_s_addr", 32'(mem0.s_addr), 32'd0);
    check_val("rst_d_addr", 32'(mem0.d_addr), 32'd0);
    init_wen = 1'b0; init_addr = 8'h00;
    reset_n = 1'b1;
    @(negedge clk);

    // All-valid message: first key wins.
    start_search(0);
    wait_and_check(0, 0, 24'h3FFFFF);

    // Keys 0..2 carry an uppercase byte at idx 5.
    for (int k = 0; k < 3; k++) begin bad_idx[k] = 5; bad_chr[k] = 8'h41; end
    start_search(0);
    wait_and_check(0, 0, 24'h3FFFFF);
    clear_bad();

    // Single-key space with a bad message: fail, key stays at 5.
    bad_idx[5] = int'($urandom_range(0, 31));
    start_search(1);
    wait_and_check(1, 5, 5);
    clear_bad();

    // Spurious ksa_done and a repeated start during INIT_WAIT.
    lat_init = 12;
    start_search(0);
    @(negedge clk);
    r1 = 8'($urandom);
    force_ksa = 1'b1; start_r[0] = 1'b1; init_wen = 1'b1; init_addr = r1;
    @(negedge clk);
    force_ksa = 1'b0; start_r[0] = 1'b0;
    check_val("spur_ksa_start", 32'(ksa_start_w[0]), 32'd0);
    check_val("spur_key", 32'(key_w[0]), 32'd0);
    check_val("spur_grant_init_wen", 32'(mem0.s_wen), 32'd1);
    check_val("spur_grant_init_addr", 32'(mem0.s_addr), 32'(r1));
    repeat (2) @(negedge clk);
    check_val("spur_ksa_start_late", 32'(ksa_start_w[0]), 32'd0);
    init_wen = 1'b0; init_addr = 8'h00;
    wait_and_check(0, 0, 24'h3FFFFF);
    lat_init = 3;

    // Decrypt-phase routing by dec_sel.
    lat_dec = 15;
    start_search(0);
    for (n = 0; n < 200 && !dec_start_w[0]; n++) @(negedge clk);
    check_val("dec_start_seen", 32'(dec_start_w[0]), 32'd1);
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      dec_sel = 2'd2; dec_addr = r1; dec_wen = 1'b1; e_q_r = r2; s_q_r = r3;
      #1;
      check_val("enc_e_addr", 32'(mem0.e_addr), 32'(r1));
      check_val("enc_dec_q", 32'(dec_q_w[0]), 32'(r2));
      check_val("enc_s_wen", 32'(mem0.s_wen), 32'd0);
      dec_sel = 2'd3; dec_data = r3;
      #1;
      check_val("decram_d_wen", 32'(mem0.d_wen), 32'd1);
      check_val("decram_d_addr", 32'(mem0.d_addr), 32'(r1));
      check_val("decram_d_data", 32'(mem0.d_data), 32'(r3));
      check_val("decram_s_wen", 32'(mem0.s_wen), 32'd0);
      @(negedge clk);
    end
    dec_sel = 2'd0; dec_addr = 8'h00; dec_wen = 1'b0; dec_data = 8'h00;
    wait_and_check(0, 0, 24'h3FFFFF);
    lat_dec = 3;

    // Randomized searches against the model.
    for (int s = 0; s < 6; s++) begin
      int nbad;
      clear_bad();
      for (int i = 0; i < 32; i++) begin
        int c = int'($urandom_range(0, 26));
        msg_txt[i] = (c == 26) ? 8'h20 : 8'(8'h61 + c);
      end
      nbad = int'($urandom_range(0, 4));
      for (int k = 0; k < nbad; k++) begin
        bad_idx[k] = int'($urandom_range(0, 31));
        do bad_chr[k] = 8'($urandom); while (printable(bad_chr[k]));
      end
      lat_init = int'($urandom_range(1, 5));
      lat_ksa  = int'($urandom_range(1, 5));
      lat_dec  = int'($urandom_range(1, 5));
      start_search(0);
      wait_and_check(0, 0, 24'h3FFFFF);
    end
    lat_init = 3; lat_ksa = 3; lat_dec = 3;

    // Asynchronous reset in the middle of the second key's KSA phase.
    clear_bad();
    bad_idx[0] = int'($urandom_range(0, 31));
    bad_idx[1] = int'($urandom_range(0, 31));
    lat_ksa = 10;
    start_search(0);
    for (n = 0; n < 2000 && !(ksa_start_w[0] && key_w[0] == 24'd1); n++) @(negedge clk);
    check_val("ksa_key1_seen", 32'(key_w[0]), 32'd1);
    @(negedge clk);
    r1 = 8'($urandom); r2 = 8'($urandom);
    ksa_wen = 1'b1; ksa_addr = r1; ksa_data = r2;
    #1;
    check_val("ksa_s_wen", 32'(mem0.s_wen), 32'd1);
    check_val("ksa_s_addr", 32'(mem0.s_addr), 32'(r1));
    check_val("ksa_s_data", 32'(mem0.s_data), 32'(r2));
    reset_n = 1'b0;
    #1;
    check_val("midrst_busy", 32'(busy_w[0]), 32'd0);
    check_val("midrst_key", 32'(key_w[0]), 32'd0);
    check_val("midrst_s_wen", 32'(mem0.s_wen), 32'd0);
    check_val("midrst_s_addr", 32'(mem0.s_addr), 32'd0);
    @(negedge clk);
    ksa_wen = 1'b0; ksa_addr = 8'h00; ksa_data = 8'h00;
    reset_n = 1'b1;
    @(negedge clk);
    check_val("after_rst_found", 32'(found_w[0]), 32'd0);
    check_val("after_rst_init_start", 32'(init_start_w[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
